// File: rtl/bcd_serial_add_ctrl.sv
// Packed-BCD adder sequencer: one digit per cycle through a shared single-digit BCD adder, LSD first.
// Latency: done pulses NDIG+1 cycles after an accepted start (1 cycle when an operand digit is invalid).
// Backpressure: start is only honoured while idle; requests arriving while busy are dropped, not queued.
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic [4*NDIG-1:0] op_a,
    input  logic [4*NDIG-1:0] op_b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result,
    output logic              cout,
    output logic              err,
    output logic [3:0]        dig_a,
    output logic [3:0]        dig_b,
    output logic              dig_cin,
    input  logic [3:0]        dig_sum,
    input  logic              dig_cout
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    // True when any nibble of the packed BCD word is a non-decimal code (A..F).
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Next-state, datapath updates and the shared-adder operand mux.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        err_d    = err_q;
        dig_a    = 4'd0;
        dig_b    = 4'd0;
        dig_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    if (has_bad_digit(op_a) || has_bad_digit(op_b)) begin
                        // Reject up front: nothing sensible to add, report a clean zero.
                        err_d    = 1'b1;
                        result_d = '0;
                        cout_d   = 1'b0;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                // Constant-index select keeps the digit mux free of variable shifts.
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IW'(i)) begin
                        dig_a = a_q[4*i +: 4];
                        dig_b = b_q[4*i +: 4];
                        result_d[4*i +: 4] = dig_sum;
                    end
                end
                dig_cin = carry_q;
                carry_d = dig_cout;
                // A non-decimal sum means the external adder misbehaved; keep the digit anyway.
                if (dig_sum > 4'd9) begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_cout;
                    idx_d   = '0;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FIN);
    assign result = result_q;
    assign cout   = cout_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: decimal-arithmetic reference model, per-cycle compare, directed + random ops.
// Latency: n/a (bench).
// Backpressure: n/a (bench); exercises dropped starts and start held high.
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b1;
    logic          start    = 1'b0;
    logic [W-1:0]  op_a     = '0;
    logic [W-1:0]  op_b     = '0;
    logic          cin      = 1'b0;
    logic          busy, done, cout, err, dig_cin, dig_cout;
    logic [W-1:0]  result;
    logic [3:0]    dig_a, dig_b, dig_sum;
    logic          fault    = 1'b0;

    int n_tot = 0;
    int n_bad = 0;

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .err      (err),
        .dig_a    (dig_a),
        .dig_b    (dig_b),
        .dig_cin  (dig_cin),
        .dig_sum  (dig_sum),
        .dig_cout (dig_cout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Shared single-digit BCD adder; fault mode returns a non-decimal sum code.
    always_comb begin
        int s;
        s        = int'(dig_a) + int'(dig_b) + int'(dig_cin);
        dig_cout = (s > 9);
        dig_sum  = fault ? 4'd12 : ((s > 9) ? 4'(s - 10) : 4'(s));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint p10(input int k);
        longint r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r;
        r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint x);
        logic [W-1:0] r;
        longint t;
        t = x;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic bad_bcd(input logic [W-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [W-1:0] rnd_bcd();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if ($urandom_range(0, 39) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else                            r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Reference model: an accepted operation lasts m_len cycles; m_t is the cycle number within it.
    bit           m_act   = 1'b0;
    int           m_t     = 0;
    int           m_len   = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic [W-1:0] m_res   = '0;
    logic         m_cin   = 1'b0;
    logic         m_cout  = 1'b0;
    logic         m_err   = 1'b0;

    // Advance the model on each clock; final answers are computed arithmetically at acceptance.
    always @(posedge CLOCK_50 or negedge resetn) begin
        longint sum;
        if (!resetn) begin
            m_act = 1'b0; m_t = 0; m_res = '0; m_cout = 1'b0; m_err = 1'b0; m_valid = 1'b0;
        end else if (m_act) begin
            if (m_t == m_len) m_act = 1'b0;
            else m_t++;
        end else if (start) begin
            m_a = op_a; m_b = op_b; m_cin = cin;
            m_act = 1'b1; m_t = 1;
            if (bad_bcd(op_a) || bad_bcd(op_b)) begin
                m_valid = 1'b0; m_len = 1; m_res = '0; m_cout = 1'b0; m_err = 1'b1;
            end else begin
                sum     = bcd2int(op_a) + bcd2int(op_b) + longint'(cin);
                m_valid = 1'b1;
                m_len   = NDIG + 1;
                m_cout  = (sum >= p10(NDIG));
                m_err   = fault;
                if (fault) begin
                    for (int i = 0; i < NDIG; i++) m_res[4*i +: 4] = 4'd12;
                end else begin
                    m_res = int2bcd(sum % p10(NDIG));
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge CLOCK_50) begin
        logic [3:0] ea, eb;
        logic       ec;
        int         k;
        ea = 4'd0; eb = 4'd0; ec = 1'b0;
        if (m_act && m_valid && m_t <= NDIG) begin
            k  = m_t - 1;
            ea = m_a[4*k +: 4];
            eb = m_b[4*k +: 4];
            if (k == 0) ec = m_cin;
            else ec = ((bcd2int(m_a) % p10(k)) + (bcd2int(m_b) % p10(k)) + longint'(m_cin)) >= p10(k);
        end
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_act && m_t == m_len));
        chk("dig_a", 32'(dig_a), 32'(ea));
        chk("dig_b", 32'(dig_b), 32'(eb));
        chk("dig_cin", 32'(dig_cin), 32'(ec));
        if (!m_act || m_t == m_len) begin
            chk("result", 32'(result), 32'(m_res));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output logic [31:0] adig, output logic [31:0] bdig,
                          output logic [7:0] cins);
        @(posedge CLOCK_50); #2;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(posedge CLOCK_50); #2;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        lat = 0; adig = '0; bdig = '0; cins = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (busy && !done) begin
                adig = {adig[27:0], dig_a};
                bdig = {bdig[27:0], dig_b};
                cins = {cins[6:0], dig_cin};
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge CLOCK_50); #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int           lat, nd, first, last, gap_ok, blow;
        logic [31:0]  ad, bd;
        logic [7:0]   cs;

        #1 resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_dig_a", 32'(dig_a), 32'd0);
        resetn = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, lat, ad, bd, cs);
        chk("t1_lat", 32'(lat), 32'd5);
        chk("t1_result", 32'(result), 32'h6912);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_dig_a_seq", ad, 32'h4321);
        chk("t1_dig_b_seq", bd, 32'h8765);

        run_op(16'h9999, 16'h0001, 1'b0, lat, ad, bd, cs);
        chk("t2_result", 32'(result), 32'h0000);
        chk("t2_cout", 32'(cout), 32'd1);
        chk("t2_cin_seq", 32'(cs), 32'b0111);

        run_op(16'h0000, 16'h0000, 1'b1, lat, ad, bd, cs);
        chk("t3_result", 32'(result), 32'h0001);
        chk("t3_cout", 32'(cout), 32'd0);
        run_op(16'h9999, 16'h9999, 1'b1, lat, ad, bd, cs);
        chk("t3b_result", 32'(result), 32'h9999);
        chk("t3b_cout", 32'(cout), 32'd1);

        run_op(16'h12A4, 16'h0001, 1'b0, lat, ad, bd, cs);
        chk("t4_lat", 32'(lat), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_result", 32'(result), 32'd0);
        chk("t4_cout", 32'(cout), 32'd0);
        chk("t4_dig_a_seq", ad, 32'd0);
        wait_idle();
        run_op(16'h0005, 16'h0004, 1'b0, lat, ad, bd, cs);
        chk("t4b_err", 32'(err), 32'd0);
        chk("t4b_result", 32'(result), 32'h0009);
        wait_idle();

        // Extra start pulses during an operation must be dropped.
        @(posedge CLOCK_50); #2;
        op_a = 16'h0417; op_b = 16'h0385; cin = 1'b0; start = 1'b1;
        @(posedge CLOCK_50); #2;
        start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLOCK_50);
            if (done) nd++;
            @(posedge CLOCK_50); #2;
            start = (i == 1 || i == 3);
        end
        start = 1'b0;
        chk("t5_done_count", 32'(nd), 32'd1);
        chk("t5_result", 32'(result), 32'h0802);

        // start held high: back-to-back operations.
        @(posedge CLOCK_50); #2;
        op_a = 16'h2500; op_b = 16'h2500; cin = 1'b0; start = 1'b1;
        @(posedge CLOCK_50);
        nd = 0; first = 0; last = 0; gap_ok = 1; blow = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge CLOCK_50);
            if (!busy) blow++;
            if (done) begin
                if (nd == 0) first = i;
                else if (i - last != 6) gap_ok = 0;
                last = i;
                nd++;
            end
        end
        @(posedge CLOCK_50); #2;
        start = 1'b0;
        chk("t6_done_count", 32'(nd), 32'd3);
        chk("t6_first_done", 32'(first), 32'd5);
        chk("t6_spacing", 32'(gap_ok), 32'd1);
        chk("t6_busy_low", 32'(blow), 32'd2);
        wait_idle();

        // Reset in the middle of an addition.
        @(posedge CLOCK_50); #2;
        op_a = 16'h2222; op_b = 16'h3333; cin = 1'b1; start = 1'b1;
        @(posedge CLOCK_50); #2;
        start = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50); #2;
        resetn = 1'b0;
        #1;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        chk("t7_result", 32'(result), 32'd0);
        chk("t7_dig_a", 32'(dig_a), 32'd0);
        chk("t7_dig_cin", 32'(dig_cin), 32'd0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            if (done) nd++;
        end
        chk("t7_no_done", 32'(nd), 32'd0);
        @(posedge CLOCK_50); #2;
        resetn = 1'b1;
        run_op(16'h4567, 16'h5433, 1'b0, lat, ad, bd, cs);
        chk("t7b_lat", 32'(lat), 32'd5);
        chk("t7b_result", 32'(result), 32'h0000);
        chk("t7b_cout", 32'(cout), 32'd1);
        wait_idle();

        // Random traffic: random starts, operands changing every cycle, occasional adder faults.
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLOCK_50); #2;
            if (!busy) fault = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 2) == 0);
            op_a  = rnd_bcd();
            op_b  = rnd_bcd();
            cin   = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        wait_idle();
        fault = 1'b0;
        repeat (3) @(posedge CLOCK_50);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
